// File: rtl/dffs_pipe.sv
// dffs_pipe: DEPTH-stage data/valid shift register with clock enable, sync clear/preset and occupancy count
// Ports: clk, rst (sync, active-high), ce (shift enable), sclr/sset (sync clear/preset),
//        din/din_valid (stage 0 input), dout/dout_valid (last stage), occ (valid-stage count).
// Optional macro DFFS_PIPE_PARITY_EN adds err_inj input, par_err output and one parity bit per stage.
module dffs_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       sclr,
  input  logic                       sset,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
`ifdef DFFS_PIPE_PARITY_EN
  input  logic                       err_inj,
  output logic                       par_err,
`endif
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] occ
);
  localparam int OW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  assign dout = d[DEPTH-1];
  assign dout_valid = v[DEPTH-1];
  // occ tracks popcount(v) incrementally: a shift adds the entering bit and drops the leaving one
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= INIT;
      v <= '0;
      occ <= '0;
    end else if (sclr) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      v <= '0;
      occ <= '0;
    end else if (sset) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= '1;
      v <= '1;
      occ <= OW'(DEPTH);
    end else if (ce) begin
      d[0] <= din;
      for (int i = 1; i < DEPTH; i++) d[i] <= d[i-1];
      v <= DEPTH'({v, din_valid});
      occ <= occ + OW'(din_valid) - OW'(v[DEPTH-1]);
    end
  end
`ifdef DFFS_PIPE_PARITY_EN
  logic [DEPTH-1:0] p;
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= {DEPTH{^INIT}};
      par_err <= 1'b0;
    end else if (sclr) begin
      p <= '0;
      par_err <= 1'b0;
    end else begin
      if (sset) p <= {DEPTH{^{WIDTH{1'b1}}}};
      else if (ce) p <= DEPTH'({p, (^din) ^ err_inj});
      if (dout_valid && ((^dout) != p[DEPTH-1])) par_err <= 1'b1;
    end
  end
`endif
endmodule

// File: doc/dffs_pipe.md
DFFS_PIPE -- requirements
Module: dffs_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (legal range 1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (legal range 1..16).
REQ-003 SHALL have parameter INIT, default {WIDTH{1'b0}}, data value loaded into every stage by reset.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ce  input  1  clock enable; shift when high.
REQ-007 SHALL have port sclr  input  1  synchronous clear of data and valid bits.
REQ-008 SHALL have port sset  input  1  synchronous preset of data and valid bits.
REQ-009 SHALL have port din  input  WIDTH  data into stage 0.
REQ-010 SHALL have port din_valid  input  1  qualifier for din.
REQ-011 SHALL have port dout  output  WIDTH  last stage data (stage DEPTH-1), registered.
REQ-012 SHALL have port dout_valid  output  1  last stage valid bit.
REQ-013 SHALL have port occ  output  $clog2(DEPTH+1)  count of stages holding valid bits.

Function
REQ-014 SHALL apply per edge the priority rst > sclr > sset > ce > hold.
REQ-015 SHALL, on sclr, set all stage data to 0 and all valid bits to 0, regardless of ce.
REQ-016 SHALL, on sset (no rst/sclr), set all stage data to all-ones and all valid bits to 1, regardless of ce.
REQ-017 SHALL, on ce=1 (no rst/sclr/sset), load stage0 <= din, valid0 <= din_valid, and stage k <= stage k-1 for k = 1..DEPTH-1.
REQ-018 SHALL hold all stages, valid bits and occ unchanged when ce=0 and no rst/sclr/sset.
REQ-019 SHALL give latency din -> dout of exactly DEPTH ce-qualified edges; ce-low cycles add stall, never drop or duplicate data.
REQ-020 SHALL register occ and keep it equal to the popcount of the valid bits after every edge: +1 when entering valid=1 and leaving valid=0, -1 for the converse, unchanged otherwise.
REQ-021 SHALL saturate occ at DEPTH (all valid) and at 0 (all invalid); no wrap.
REQ-022 SHALL, for DEPTH=1, make dout equal to din registered on one ce edge.
REQ-023 SHALL let sclr/sset asserted with ce=1 take effect without also shifting that edge.

Reset
REQ-024 SHALL, on rst=1 at a rising clk edge, set every stage to INIT, all valid bits to 0, occ to 0, so that dout=INIT and dout_valid=0.
REQ-025 SHALL abort any in-flight data when rst is asserted mid-stream; first valid output after release follows DEPTH ce edges later.
REQ-026 SHALL have no asynchronous set or reset path in any flop.

Configuration
REQ-027 SHALL support macro DFFS_PIPE_PARITY_EN; when undefined, ports err_inj and par_err are absent and no parity logic exists.
REQ-028 SHALL, with DFFS_PIPE_PARITY_EN defined, add input err_inj (1 bit) and output par_err (1 bit), plus one parity bit per stage that moves with data.
REQ-029 SHALL, with the macro defined, store parity0 <= (^din) ^ err_inj on ce shift; sset stores parity = WIDTH odd ? 1 : 0; rst/sclr store parity of stored data.
REQ-030 SHALL, with the macro defined, set par_err sticky on the edge after dout_valid=1 and ^dout != last-stage parity; cleared only by rst or sclr.

Verification
REQ-031 SHALL verify reset: WIDTH=8, DEPTH=4, INIT=8'hA5, rst one cycle -> dout=8'hA5, dout_valid=0, occ=0.
REQ-032 SHALL verify latency: ce=1, din_valid=1, din=8'h01,02,03,... -> dout=8'h01 with dout_valid=1 on 4th edge; occ ramps 1,2,3,4 and stays 4.
REQ-033 SHALL verify stall: toggle ce 1/0 every cycle on the same stream -> dout sequence 01,02,03 with no gaps or repeats, each after 4 ce-high edges.
REQ-034 SHALL verify priority: assert sclr and sset together with ce=1 -> dout=0, dout_valid=0, occ=0; then sset alone -> dout=8'hFF, occ=4.
REQ-035 SHALL verify mid-stream reset: rst at occ=3 -> occ=0 next edge, dout=INIT, and first new valid output 4 ce edges after rst release.
REQ-036 SHALL verify parity (macro defined): err_inj=1 on one word 8'h3C -> par_err=1 one edge after it reaches dout; stays 1 until sclr.
